// File: rtl/trap_csr_if.sv
// Trap stage <-> trap_csr connection: trap requests, CSR bus and interrupt/redirect feedback.
`default_nettype none

interface trap_csr_if;
  logic        mem_wait;
  logic        trap_en;
  logic [31:0] trap_pc;
  logic [31:0] trap_code;
  logic [31:0] trap_jmp_to;
  logic        mret_en;
  logic        ext_int;
  logic        timer_int;
  logic        soft_int;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic [1:0]  trap_vec_mode;
  logic [31:0] trap_vec_base;
  logic        int_allow;
  logic        int_en;
  logic [3:0]  int_code;
  logic        flush_en;
  logic [31:0] new_pc;

  modport master (
    output mem_wait, trap_en, trap_pc, trap_code, trap_jmp_to, mret_en,
           ext_int, timer_int, soft_int, csr_rd_addr, csr_wr_en, csr_wr_addr, csr_wr_data,
    input  csr_rd_data, trap_vec_mode, trap_vec_base, int_allow, int_en, int_code,
           flush_en, new_pc
  );

  modport slave (
    input  mem_wait, trap_en, trap_pc, trap_code, trap_jmp_to, mret_en,
           ext_int, timer_int, soft_int, csr_rd_addr, csr_wr_en, csr_wr_addr, csr_wr_data,
    output csr_rd_data, trap_vec_mode, trap_vec_base, int_allow, int_en, int_code,
           flush_en, new_pc
  );
endinterface

`default_nettype wire

// File: rtl/trap_csr.sv
// ============================================================================
// trap_csr : machine-mode trap CSRs, trap/MRET redirect FSM, interrupt request
// Revision : 1.0
// ============================================================================
`default_nettype none

module trap_csr #(
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter logic        MSTATUS_MIE = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  trap_csr_if.slave    bus
);

  localparam logic [1:0]  IDLE     = 2'd0;
  localparam logic [1:0]  REDIRECT = 2'd1;
  localparam logic [1:0]  SETTLE   = 2'd2;
  localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

  logic [1:0]  state_q, state_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic        mstie_q, mstie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mip_q, mip_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        int_en_q, int_en_d;
  logic [3:0]  int_code_q, int_code_d;

  logic        accept;
  logic        take_trap;
  logic        take_mret;
  logic        wr_ok;
  logic [31:0] pend;

  assign accept    = (state_q == IDLE) && !bus.mem_wait;
  assign take_trap = accept && bus.trap_en;
  assign take_mret = accept && bus.mret_en && !bus.trap_en;
  assign wr_ok     = accept && bus.csr_wr_en;

  assign mip_d = {20'b0, bus.ext_int, 3'b0, bus.timer_int, 3'b0, bus.soft_int, 3'b0};
  assign pend  = mip_d & mie_q;

  always_comb begin
    state_d    = state_q;
    mtvec_d    = mtvec_q;
    mstie_d    = mstie_q;
    mpie_d     = mpie_q;
    mie_d      = mie_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    new_pc_d   = new_pc_q;
    int_en_d   = |pend;
    int_code_d = 4'd0;

    if (pend[11])     int_code_d = 4'd11;
    else if (pend[3]) int_code_d = 4'd3;
    else if (pend[7]) int_code_d = 4'd7;

    if (wr_ok) begin
      case (bus.csr_wr_addr)
        12'h300: begin
          mstie_d = bus.csr_wr_data[3];
          mpie_d  = bus.csr_wr_data[7];
        end
        12'h304: mie_d    = bus.csr_wr_data & IRQ_MASK;
        12'h305: mtvec_d  = bus.csr_wr_data;
        12'h341: mepc_d   = bus.csr_wr_data & ~32'h3;
        12'h342: mcause_d = bus.csr_wr_data;
        default: ;
      endcase
    end

    // Trap/MRET updates come after the CSR write so they win on shared registers.
    case (state_q)
      IDLE: begin
        if (take_trap) begin
          mepc_d   = bus.trap_pc & ~32'h3;
          mcause_d = bus.trap_code;
          mpie_d   = mstie_q;
          mstie_d  = 1'b0;
          new_pc_d = bus.trap_jmp_to;
          state_d  = REDIRECT;
        end else if (take_mret) begin
          mstie_d  = mpie_q;
          mpie_d   = 1'b1;
          new_pc_d = mepc_q;
          state_d  = REDIRECT;
        end
      end
      REDIRECT: state_d = SETTLE;
      SETTLE:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mtvec_q    <= MTVEC_RST;
      mstie_q    <= MSTATUS_MIE;
      mpie_q     <= 1'b0;
      mie_q      <= 32'h0;
      mip_q      <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      new_pc_q   <= 32'h0;
      int_en_q   <= 1'b0;
      int_code_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      mtvec_q    <= mtvec_d;
      mstie_q    <= mstie_d;
      mpie_q     <= mpie_d;
      mie_q      <= mie_d;
      mip_q      <= mip_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      new_pc_q   <= new_pc_d;
      int_en_q   <= int_en_d;
      int_code_q <= int_code_d;
    end
  end

  always_comb begin
    bus.csr_rd_data = 32'h0;
    case (bus.csr_rd_addr)
      12'h300: bus.csr_rd_data = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mstie_q, 3'b0};
      12'h304: bus.csr_rd_data = mie_q;
      12'h305: bus.csr_rd_data = mtvec_q;
      12'h341: bus.csr_rd_data = mepc_q;
      12'h342: bus.csr_rd_data = mcause_q;
      12'h344: bus.csr_rd_data = mip_q;
      default: bus.csr_rd_data = 32'h0;
    endcase
  end

  assign bus.trap_vec_mode = mtvec_q[1:0];
  assign bus.trap_vec_base = {mtvec_q[31:2], 2'b00};
  assign bus.int_allow     = mstie_q && (state_q == IDLE);
  assign bus.int_en        = int_en_q;
  assign bus.int_code      = int_code_q;
  assign bus.flush_en      = (state_q == REDIRECT);
  assign bus.new_pc        = new_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_trap_csr.sv
// Directed bench for trap_csr: reset, trap/MRET redirect, interrupts, same-cycle cases.
`default_nettype none

module tb_trap_csr;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  trap_csr_if bus ();

  trap_csr #(.MTVEC_RST(32'h100), .MSTATUS_MIE(1'b0)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    bus.csr_rd_addr = a;
    #1;
    d = bus.csr_rd_data;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_wr_en   = 1'b1;
    bus.csr_wr_addr = a;
    bus.csr_wr_data = d;
    tick();
    bus.csr_wr_en   = 1'b0;
  endtask

  task automatic set_trap(input logic [31:0] pc, input logic [31:0] code, input logic [31:0] jmp);
    bus.trap_en     = 1'b1;
    bus.trap_pc     = pc;
    bus.trap_code   = code;
    bus.trap_jmp_to = jmp;
  endtask

  logic [31:0] d;

  initial begin
    bus.mem_wait = 0; bus.trap_en = 0; bus.trap_pc = 0; bus.trap_code = 0;
    bus.trap_jmp_to = 0; bus.mret_en = 0; bus.ext_int = 0; bus.timer_int = 0;
    bus.soft_int = 0; bus.csr_rd_addr = 0; bus.csr_wr_en = 0; bus.csr_wr_addr = 0;
    bus.csr_wr_data = 0;
    tick(); tick();
    rst_i = 1'b0;
    tick();

    chk("rst_vec_base", bus.trap_vec_base, 32'h100);
    chk("rst_vec_mode", {30'b0, bus.trap_vec_mode}, 32'h0);
    chk("rst_flush", {31'b0, bus.flush_en}, 32'h0);
    chk("rst_int_allow", {31'b0, bus.int_allow}, 32'h0);
    chk("rst_int_en", {31'b0, bus.int_en}, 32'h0);
    chk("rst_new_pc", bus.new_pc, 32'h0);
    rd(12'h300, d); chk("rst_mstatus", d, 32'h1800);

    wr(12'h300, 32'h8);
    rd(12'h300, d); chk("mstatus_mie_set", d, 32'h1808);
    chk("int_allow_on", {31'b0, bus.int_allow}, 32'h1);

    // Trap entry
    set_trap(32'h2002, 32'h2, 32'h100);
    tick();
    bus.trap_en = 1'b0;
    chk("trap_flush", {31'b0, bus.flush_en}, 32'h1);
    chk("trap_new_pc", bus.new_pc, 32'h100);
    tick();
    chk("trap_flush_end", {31'b0, bus.flush_en}, 32'h0);
    tick();
    rd(12'h341, d); chk("trap_mepc", d, 32'h2000);
    rd(12'h342, d); chk("trap_mcause", d, 32'h2);
    rd(12'h300, d); chk("trap_mstatus", d, 32'h1880);

    // MRET
    bus.mret_en = 1'b1;
    tick();
    bus.mret_en = 1'b0;
    chk("mret_flush", {31'b0, bus.flush_en}, 32'h1);
    chk("mret_new_pc", bus.new_pc, 32'h2000);
    tick();
    chk("mret_flush_end", {31'b0, bus.flush_en}, 32'h0);
    tick();
    rd(12'h300, d); chk("mret_mstatus", d, 32'h1888);
    chk("mret_int_allow", {31'b0, bus.int_allow}, 32'h1);

    // Interrupts
    wr(12'h304, 32'hFFFF_FFFF);
    rd(12'h304, d); chk("mie_mask", d, 32'h888);
    bus.ext_int = 1'b1; bus.timer_int = 1'b1;
    tick(); tick();
    chk("irq_en", {31'b0, bus.int_en}, 32'h1);
    chk("irq_code_ext", {28'b0, bus.int_code}, 32'd11);
    bus.ext_int = 1'b0;
    tick(); tick();
    chk("irq_code_timer", {28'b0, bus.int_code}, 32'd7);
    bus.soft_int = 1'b1;
    tick(); tick();
    chk("irq_code_soft", {28'b0, bus.int_code}, 32'd3);
    rd(12'h344, d); chk("mip_read", d, 32'h88);
    bus.soft_int = 1'b0; bus.timer_int = 1'b0;
    tick(); tick();
    chk("irq_off", {31'b0, bus.int_en}, 32'h0);
    chk("irq_code_none", {28'b0, bus.int_code}, 32'd0);

    // Trap and MRET together, then a stale trap during SETTLE
    set_trap(32'h4000, 32'h5, 32'h200);
    bus.mret_en = 1'b1;
    tick();
    bus.trap_en = 1'b0; bus.mret_en = 1'b0;
    chk("both_new_pc", bus.new_pc, 32'h200);
    chk("both_flush", {31'b0, bus.flush_en}, 32'h1);
    tick();
    set_trap(32'h4444, 32'h9, 32'h300);
    tick();
    bus.trap_en = 1'b0;
    chk("settle_no_flush", {31'b0, bus.flush_en}, 32'h0);
    tick();
    chk("settle_no_flush2", {31'b0, bus.flush_en}, 32'h0);
    rd(12'h342, d); chk("settle_mcause", d, 32'h5);
    rd(12'h341, d); chk("both_mepc", d, 32'h4000);

    // MEM_WAIT blocks acceptance and CSR writes
    bus.mem_wait = 1'b1;
    set_trap(32'h5000, 32'h6, 32'h400);
    bus.csr_wr_en = 1'b1; bus.csr_wr_addr = 12'h342; bus.csr_wr_data = 32'hAA;
    tick();
    bus.csr_wr_en = 1'b0;
    chk("wait_no_flush", {31'b0, bus.flush_en}, 32'h0);
    tick();
    chk("wait_no_flush2", {31'b0, bus.flush_en}, 32'h0);
    rd(12'h342, d); chk("wait_no_write", d, 32'h5);
    bus.mem_wait = 1'b0;
    tick();
    bus.trap_en = 1'b0;
    chk("wait_flush", {31'b0, bus.flush_en}, 32'h1);
    chk("wait_new_pc", bus.new_pc, 32'h400);
    tick(); tick();

    // Masked mepc and unknown CSR
    wr(12'h341, 32'h3);
    rd(12'h341, d); chk("mepc_mask", d, 32'h0);
    wr(12'h7C0, 32'h1234);
    rd(12'h7C0, d); chk("unknown_csr", d, 32'h0);

    // CSR write to mtvec on the trap-accept edge still lands
    set_trap(32'h6000, 32'h7, 32'h500);
    wr(12'h305, 32'h205);
    bus.trap_en = 1'b0;
    chk("wrtrap_flush", {31'b0, bus.flush_en}, 32'h1);
    chk("wrtrap_vec_base", bus.trap_vec_base, 32'h204);
    chk("wrtrap_vec_mode", {30'b0, bus.trap_vec_mode}, 32'h1);
    tick(); tick();
    rd(12'h341, d); chk("wrtrap_mepc", d, 32'h6000);

    // Reset during REDIRECT
    set_trap(32'h7000, 32'h8, 32'h600);
    tick();
    bus.trap_en = 1'b0;
    chk("rstmid_flush_pre", {31'b0, bus.flush_en}, 32'h1);
    rst_i = 1'b1;
    #1;
    chk("rstmid_flush", {31'b0, bus.flush_en}, 32'h0);
    chk("rstmid_vec_base", bus.trap_vec_base, 32'h100);
    chk("rstmid_new_pc", bus.new_pc, 32'h0);
    tick();
    rst_i = 1'b0;
    tick();
    rd(12'h341, d); chk("rstmid_mepc", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
